// File: rtl/vga_console_pkg.sv
// Shared types, ASCII codes and cmem bus packing helpers for the VGA text console.
package vga_console_pkg;

  typedef enum logic [1:0] {CLEAR, IDLE, LINECLR} state_t;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  function automatic logic [31:0] cm_pack_addr(input logic [4:0] row, input logic [6:0] col);
    return {19'b0, col, row, 1'b0};
  endfunction

  function automatic logic [31:0] cm_pack_din(input logic [7:0] ascii, input logic [2:0] fg,
                                              input logic [2:0] bg);
    return {18'b0, bg, fg, ascii};
  endfunction

endpackage

// File: rtl/vga_console_sweep.sv
// Row-major cell walker for clear sweeps; row_only confines the walk to one row.
module vga_console_sweep #(
  parameter int ROWS = 30,
  parameter int COLS = 70
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       row_only,
  input  logic [4:0] start_row,
  input  logic       step,
  output logic [4:0] row,
  output logic [6:0] col,
  output logic       done
);

  logic row_only_q;
  logic at_last_col;

  assign at_last_col = (col == 7'(COLS - 1));
  assign done        = step && at_last_col && (row_only_q || row == 5'(ROWS - 1));

  // Reset state doubles as the start of the post-reset full-screen sweep.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row        <= '0;
      col        <= '0;
      row_only_q <= 1'b0;
    end else if (start) begin
      row        <= start_row;
      col        <= '0;
      row_only_q <= row_only;
    end else if (step) begin
      if (at_last_col) begin
        col <= '0;
        if (!row_only_q) row <= (row == 5'(ROWS - 1)) ? '0 : row + 5'd1;
      end else begin
        col <= col + 7'd1;
      end
    end
  end

endmodule

// File: rtl/vga_console_ctrl.sv
// Character stream to cmem write sequencer with cursor, control codes and clear sweeps.
// Optional: define VGA_CONSOLE_FF_CLEAR_EN to make form feed home the cursor and clear the screen.
module vga_console_ctrl
  import vga_console_pkg::*;
#(
  parameter int         ROWS   = 30,
  parameter int         COLS   = 70,
  parameter logic [2:0] DEF_FG = 3'b111,
  parameter logic [2:0] DEF_BG = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic [2:0]  in_fg,
  input  logic [2:0]  in_bg,
  output logic        cm_sel,
  output logic        cm_we,
  output logic [31:0] cm_addr,
  output logic [31:0] cm_din,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  state_t     state, next_state;
  logic [4:0] nrow, wr_row, row_adv, sw_row;
  logic [6:0] ncol, wr_col, sw_col;
  logic [7:0] wr_ascii;
  logic [2:0] wr_fg, wr_bg;
  logic       wr, accept, sw_start, sw_row_only, sw_step, sw_done;

  assign accept  = in_valid & in_ready;
  assign sw_step = (state != IDLE);
  assign row_adv = (cur_row == 5'(ROWS - 1)) ? '0 : cur_row + 5'd1;
  assign cm_sel  = cm_we;

  vga_console_sweep #(.ROWS(ROWS), .COLS(COLS)) u_sweep (
    .clock     (clock),
    .reset     (reset),
    .start     (sw_start),
    .row_only  (sw_row_only),
    .start_row (nrow),
    .step      (sw_step),
    .row       (sw_row),
    .col       (sw_col),
    .done      (sw_done)
  );

  always_comb begin
    next_state  = state;
    nrow        = cur_row;
    ncol        = cur_col;
    wr          = 1'b0;
    wr_row      = cur_row;
    wr_col      = cur_col;
    wr_ascii    = ASCII_SPACE;
    wr_fg       = in_fg;
    wr_bg       = in_bg;
    sw_start    = 1'b0;
    sw_row_only = 1'b1;
    case (state)
      CLEAR, LINECLR: begin
        wr     = 1'b1;
        wr_row = sw_row;
        wr_col = sw_col;
        wr_fg  = DEF_FG;
        wr_bg  = DEF_BG;
        if (sw_done) next_state = IDLE;
      end
      default: begin
        if (accept) begin
          if (in_char >= ASCII_SPACE && in_char <= ASCII_TILDE) begin
            wr       = 1'b1;
            wr_ascii = in_char;
            if (cur_col == 7'(COLS - 1)) begin
              ncol       = '0;
              nrow       = row_adv;
              sw_start   = 1'b1;
              next_state = LINECLR;
            end else begin
              ncol = cur_col + 7'd1;
            end
          end else if (in_char == ASCII_LF) begin
            ncol       = '0;
            nrow       = row_adv;
            sw_start   = 1'b1;
            next_state = LINECLR;
          end else if (in_char == ASCII_CR) begin
            ncol = '0;
          end else if (in_char == ASCII_BS && cur_col != '0) begin
            ncol   = cur_col - 7'd1;
            wr     = 1'b1;
            wr_col = cur_col - 7'd1;
          end
`ifdef VGA_CONSOLE_FF_CLEAR_EN
          else if (in_char == ASCII_FF) begin
            nrow        = '0;
            ncol        = '0;
            sw_start    = 1'b1;
            sw_row_only = 1'b0;
            next_state  = CLEAR;
          end
`endif
        end
      end
    endcase
  end

  // in_ready only rises after a full idle cycle, so it lags the last sweep write by one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      cur_row  <= '0;
      cur_col  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b1;
      cm_we    <= 1'b0;
      cm_addr  <= '0;
      cm_din   <= '0;
    end else begin
      state    <= next_state;
      cur_row  <= nrow;
      cur_col  <= ncol;
      in_ready <= (state == IDLE) && (next_state == IDLE);
      busy     <= (state != IDLE);
      cm_we    <= wr;
      if (wr) begin
        cm_addr <= cm_pack_addr(wr_row, wr_col);
        cm_din  <= cm_pack_din(wr_ascii, wr_fg, wr_bg);
      end
    end
  end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed bench for vga_console_ctrl (ROWS=30, COLS=70); honours VGA_CONSOLE_FF_CLEAR_EN.
module tb_vga_console_ctrl;

  localparam int ROWS = 30;
  localparam int COLS = 70;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic [2:0]  in_fg = 3'd0;
  logic [2:0]  in_bg = 3'd0;
  logic        cm_sel, cm_we, busy;
  logic [31:0] cm_addr, cm_din;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  int tests = 0;
  int fails = 0;

  vga_console_ctrl #(.ROWS(ROWS), .COLS(COLS), .DEF_FG(3'b111), .DEF_BG(3'b000)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_char  (in_char),
    .in_fg    (in_fg),
    .in_bg    (in_bg),
    .cm_sel   (cm_sel),
    .cm_we    (cm_we),
    .cm_addr  (cm_addr),
    .cm_din   (cm_din),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [2:0] fg, input logic [2:0] bg);
    int n = 0;
    while (in_ready !== 1'b1 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 4000) check("ready_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_char  = c;
    in_fg    = fg;
    in_bg    = bg;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic type_n(input int n);
    for (int k = 0; k < n; k++) send(8'h78, 3'd7, 3'd0);
  endtask

  // Starts one cycle before the first expected sweep write; ends on the cycle after the last.
  task automatic sweep_check(input string tag, input int n, input bit row_only, input int row);
    int bad = 0;
    logic [31:0] first_din = '0;
    logic [31:0] last_addr = '0;
    int r, c;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      r = row_only ? row : i / COLS;
      c = row_only ? i : i % COLS;
      if (cm_we !== 1'b1 || cm_sel !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
          cm_addr !== ((32'(c) << 6) | (32'(r) << 1)) || cm_din !== 32'h0720) bad++;
      if (i == 0) first_din = cm_din;
      last_addr = cm_addr;
    end
    check({tag, "_cells"}, 32'(bad), 32'd0);
    check({tag, "_first_din"}, first_din, 32'h0720);
    check({tag, "_last_addr"}, last_addr,
          (32'(row_only ? COLS - 1 : COLS - 1) << 6) | (32'(row_only ? row : ROWS - 1) << 1));
    @(negedge clock);
    check({tag, "_end_we"}, {31'b0, cm_we}, 32'd0);
    check({tag, "_end_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset state and post-reset full-screen sweep
    #3 reset = 1'b0;
    #4;
    check("rst_we", {31'b0, cm_we}, 32'd0);
    check("rst_addr", cm_addr, 32'd0);
    check("rst_din", cm_din, 32'd0);
    check("rst_cursor", {20'b0, cur_row, cur_col}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    sweep_check("clr_full", ROWS * COLS, 1'b0, 0);
    check("clr_last_literal", {20'b0, 5'd29, 7'd69}, {20'b0, 5'd29, 7'd69});
    tests--;

    // Printable character at (0,0)
    send(8'h41, 3'd2, 3'd1);
    check("a_we", {30'b0, cm_sel, cm_we}, 32'd3);
    check("a_addr", cm_addr, 32'h0);
    check("a_din", cm_din, 32'h0A41);
    check("a_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd0, 7'd1});

    // Auto-wrap from (3,69) clears row 4
    send(8'h0D, 3'd7, 3'd0);
    repeat (3) send(8'h0A, 3'd7, 3'd0);
    type_n(69);
    check("pre_z_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd3, 7'd69});
    send(8'h5A, 3'd7, 3'd0);
    check("z_we", {31'b0, cm_we}, 32'd1);
    check("z_addr", cm_addr, 32'h1146);
    check("z_din", cm_din, 32'h075A);
    check("z_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd4, 7'd0});
    check("z_ready", {31'b0, in_ready}, 32'd0);
    sweep_check("row4", COLS, 1'b1, 4);

    // Newline on the last row wraps to row 0 and clears it
    repeat (25) send(8'h0A, 3'd7, 3'd0);
    type_n(10);
    check("pre_lf_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd29, 7'd10});
    send(8'h0A, 3'd7, 3'd0);
    check("lf_we", {31'b0, cm_we}, 32'd0);
    check("lf_cursor", {20'b0, cur_row, cur_col}, 32'd0);
    sweep_check("row0", COLS, 1'b1, 0);
    type_n(5);
    send(8'h0D, 3'd7, 3'd0);
    check("cr_we", {31'b0, cm_we}, 32'd0);
    check("cr_cursor", {20'b0, cur_row, cur_col}, 32'd0);

    // Backspace, backspace at column 0, dropped control codes
    repeat (2) send(8'h0A, 3'd7, 3'd0);
    type_n(5);
    send(8'h08, 3'd5, 3'd2);
    check("bs_we", {31'b0, cm_we}, 32'd1);
    check("bs_addr", cm_addr, 32'h104);
    check("bs_din", cm_din, 32'h1520);
    check("bs_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd2, 7'd4});
    send(8'h0D, 3'd7, 3'd0);
    send(8'h08, 3'd5, 3'd2);
    check("bs0_we", {31'b0, cm_we}, 32'd0);
    check("bs0_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd2, 7'd0});
    send(8'h01, 3'd7, 3'd0);
    check("soh_we", {31'b0, cm_we}, 32'd0);
    check("soh_ready", {31'b0, in_ready}, 32'd1);
    check("soh_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd2, 7'd0});
    type_n(3);
    send(8'h0C, 3'd7, 3'd0);
    check("ff_we", {31'b0, cm_we}, 32'd0);
`ifdef VGA_CONSOLE_FF_CLEAR_EN
    check("ff_cursor", {20'b0, cur_row, cur_col}, 32'd0);
    sweep_check("ff_full", ROWS * COLS, 1'b0, 0);
`else
    check("ff_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd2, 7'd3});
    check("ff_ready", {31'b0, in_ready}, 32'd1);
`endif

    // Reset in the middle of a line clear
    send(8'h0A, 3'd7, 3'd0);
    repeat (10) @(negedge clock);
    check("mid_we", {31'b0, cm_we}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_we", {31'b0, cm_we}, 32'd0);
    check("arst_ready", {31'b0, in_ready}, 32'd0);
    check("arst_cursor", {20'b0, cur_row, cur_col}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    sweep_check("rerst_full", ROWS * COLS, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
